// File: rtl/eth_pkg.sv
// Shared types and default constants for the GMII transmit path.
package eth_pkg;

  localparam int unsigned IFG_CYCLES_DEF       = 12;
  localparam int unsigned START_TIMEOUT_DEF    = 64;
  localparam int unsigned MAX_FRAME_CYCLES_DEF = 1536;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_TX,
    ST_DRAIN,
    ST_IFG
  } tx_state_e;

  typedef struct packed {
    logic       en;
    logic [7:0] d;
  } gmii_beat_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gmii_rr_arb2.sv
// Two-request round-robin arbiter; the pointer names the port that wins a tie.
module gmii_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic [1:0] gnt_c_o
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_c_o = req_i;
    if (req_i == 2'b11) begin
      gnt_c_o = prio_q ? 2'b10 : 2'b01;
    end
  end

  // The port just served loses the next tie.
  always_comb begin
    prio_d = prio_q;
    if (take_i && (gnt_c_o != 2'b00)) begin
      prio_d = gnt_c_o[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/gmii_tx_mux.sv
// Two-port GMII transmit multiplexer with round-robin grant, start timeout,
// oversize truncation and enforced inter-frame gap.
module gmii_tx_mux
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CYCLES       = IFG_CYCLES_DEF,
  parameter int unsigned START_TIMEOUT    = START_TIMEOUT_DEF,
  parameter int unsigned MAX_FRAME_CYCLES = MAX_FRAME_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       port0_req,
  input  logic       port0_tx_en,
  input  logic [7:0] port0_txd,
  output logic       port0_sel,
  output logic       port0_done,
  input  logic       port1_req,
  input  logic       port1_tx_en,
  input  logic [7:0] port1_txd,
  output logic       port1_sel,
  output logic       port1_done,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       abort
);

  localparam int unsigned CW = $clog2(max3(IFG_CYCLES, START_TIMEOUT, MAX_FRAME_CYCLES)) + 1;
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] FRAME_MAX  = CW'(MAX_FRAME_CYCLES);
  localparam logic [CW-1:0] IFG_LAST   = CW'(IFG_CYCLES - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    done_q, done_d;
  logic          abort_q, abort_d;
  logic          gidx_q, gidx_d;
  gmii_beat_t    out_q, out_d;

  logic [1:0]    gnt_c;
  logic          take_c;
  logic          g_en, g_req;
  logic [7:0]    g_d;

  gmii_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   ({port1_req, port0_req}),
    .take_i  (take_c),
    .gnt_c_o (gnt_c)
  );

  // Granted port view; the other port's inputs never reach the output.
  assign g_en    = gidx_q ? port1_tx_en : port0_tx_en;
  assign g_req   = gidx_q ? port1_req   : port0_req;
  assign g_d     = gidx_q ? port1_txd   : port0_txd;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gidx_d  = gidx_q;
    done_d  = 2'b00;
    abort_d = 1'b0;
    out_d   = '0;
    take_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        take_c = 1'b1;
        if (gnt_c != 2'b00) begin
          sel_d   = gnt_c;
          gidx_d  = gnt_c[1];
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (g_en) begin
          out_d.en = 1'b1;
          out_d.d  = g_d;
          cnt_d    = CW'(1);
          state_d  = ST_TX;
        end else if (!g_req || (cnt_q >= START_LAST)) begin
          // A withdrawn request is a clean completion; only a timeout aborts.
          abort_d = g_req;
          done_d  = sel_q;
          sel_d   = 2'b00;
          cnt_d   = '0;
          state_d = ST_IFG;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_TX: begin
        if (!g_en) begin
          done_d  = sel_q;
          sel_d   = 2'b00;
          cnt_d   = '0;
          state_d = ST_IFG;
        end else if (cnt_q >= FRAME_MAX) begin
          abort_d = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          out_d.en = 1'b1;
          out_d.d  = g_d;
          cnt_d    = cnt_inc;
        end
      end
      ST_DRAIN: begin
        if (!g_en) begin
          done_d  = sel_q;
          sel_d   = 2'b00;
          cnt_d   = '0;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        if (cnt_q >= IFG_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      gidx_q  <= 1'b0;
      done_q  <= 2'b00;
      abort_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gidx_q  <= gidx_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      out_q   <= out_d;
    end
  end

  assign port0_sel  = sel_q[0];
  assign port1_sel  = sel_q[1];
  assign port0_done = done_q[0];
  assign port1_done = done_q[1];
  assign abort      = abort_q;
  assign gmii_tx_en = out_q.en;
  assign gmii_txd   = out_q.d;

endmodule

// File: tb/tb_gmii_tx_mux.sv
// Directed bench for gmii_tx_mux: frame table plus timeout, withdraw, reset
// and round-robin sequences.
module tb_gmii_tx_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, en0 = 1'b0, req1 = 1'b0, en1 = 1'b0;
  logic [7:0] txd0 = 8'h00, txd1 = 8'h00;
  logic       port0_sel, port0_done, port1_sel, port1_done;
  logic       gmii_tx_en, abort;
  logic [7:0] gmii_txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int abort_cnt = 0;
  int done_cnt[2] = '{0, 0};
  int last_high = -100000;
  int last_gap = -1;
  logic prev_en = 1'b0;

  typedef struct {
    int port;
    int delay;
    int len;
    int exp_len;
    int exp_abort;
    int exp_wait;
    int exp_gap;
  } frame_vec_t;

  frame_vec_t vecs[6];

  always #5 clk = ~clk;

  gmii_tx_mux dut (
    .clk         (clk),
    .rst         (rst),
    .port0_req   (req0),
    .port0_tx_en (en0),
    .port0_txd   (txd0),
    .port0_sel   (port0_sel),
    .port0_done  (port0_done),
    .port1_req   (req1),
    .port1_tx_en (en1),
    .port1_txd   (txd1),
    .port1_sel   (port1_sel),
    .port1_done  (port1_done),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .abort       (abort)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] beat(input int p, input int k);
    return 8'(k * 3 + 1 + p * 64);
  endfunction

  function automatic logic sel_of(input int p);
    return (p == 0) ? port0_sel : port1_sel;
  endfunction

  function automatic logic done_of(input int p);
    return (p == 0) ? port0_done : port1_done;
  endfunction

  task automatic drive_req(input int p, input logic v);
    if (p == 0) req0 = v; else req1 = v;
  endtask

  task automatic drive_tx(input int p, input logic e, input logic [7:0] d);
    if (p == 0) begin en0 = e; txd0 = d; end
    else begin en1 = e; txd1 = d; end
  endtask

  // Cycle monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    chk("sel_overlap", 32'(port0_sel & port1_sel), 0);
    if (!gmii_tx_en) chk("txd_idle_zero", 32'(gmii_txd), 0);
    if (abort) abort_cnt++;
    if (port0_done) done_cnt[0]++;
    if (port1_done) done_cnt[1]++;
    if (gmii_tx_en && !prev_en) last_gap = cyc - last_high - 1;
    if (gmii_tx_en) last_high = cyc;
    prev_en = gmii_tx_en;
  end

  task automatic wait_sel(input int p, output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (sel_of(p) == 1'b0 && w < 400);
  endtask

  task automatic send_frame(input int p, input int delay, input int len, input int exp_len,
                            input int exp_abort, input int exp_wait, input int exp_gap);
    int w, ab0, dn0;
    logic [7:0] prev;
    logic exp_en;
    ab0 = abort_cnt;
    dn0 = done_cnt[p];
    drive_req(p, 1'b1);
    wait_sel(p, w);
    chk("sel_wait", w, exp_wait);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("pre_frame_idle", 32'(gmii_tx_en), 0);
    end
    prev = 8'h00;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) begin
        exp_en = (k - 1 < exp_len);
        chk("beat_en", 32'(gmii_tx_en), 32'(exp_en));
        chk("beat_txd", 32'(gmii_txd), exp_en ? 32'(prev) : 0);
        chk("sel_hold", 32'(sel_of(p)), 1);
      end
      if (k < len) begin
        prev = beat(p, k);
        drive_tx(p, 1'b1, prev);
      end else begin
        drive_tx(p, 1'b0, 8'h00);
        drive_req(p, 1'b0);
      end
      @(negedge clk);
    end
    chk("done_pulse", 32'(done_of(p)), 1);
    chk("sel_drop", 32'(sel_of(p)), 0);
    chk("gmii_idle_after", 32'(gmii_tx_en), 0);
    chk("abort_count", abort_cnt - ab0, exp_abort);
    chk("done_count", done_cnt[p] - dn0, 1);
    if (exp_gap >= 0) chk("ifg_gap", last_gap, exp_gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, ab0, dn0;

    vecs[0] = '{port: 0, delay: 3, len: 60,   exp_len: 60,   exp_abort: 0, exp_wait: 1,  exp_gap: -1};
    vecs[1] = '{port: 1, delay: 0, len: 1,    exp_len: 1,    exp_abort: 0, exp_wait: 13, exp_gap: 14};
    vecs[2] = '{port: 0, delay: 1, len: 64,   exp_len: 64,   exp_abort: 0, exp_wait: 13, exp_gap: 15};
    vecs[3] = '{port: 1, delay: 2, len: 2000, exp_len: 1536, exp_abort: 1, exp_wait: 13, exp_gap: 16};
    vecs[4] = '{port: 1, delay: 0, len: 20,   exp_len: 20,   exp_abort: 0, exp_wait: 13, exp_gap: -1};
    vecs[5] = '{port: 1, delay: 0, len: 8,    exp_len: 8,    exp_abort: 0, exp_wait: 13, exp_gap: 14};

    // Reset state, including a request that must not be granted under reset.
    repeat (2) @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    chk("rst_gmii_en", 32'(gmii_tx_en), 0);
    chk("rst_gmii_txd", 32'(gmii_txd), 0);
    chk("rst_sel", 32'({port0_sel, port1_sel}), 0);
    chk("rst_done_abort", 32'({port0_done, port1_done, abort}), 0);
    req0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].port, vecs[v].delay, vecs[v].len, vecs[v].exp_len,
                 vecs[v].exp_abort, vecs[v].exp_wait, vecs[v].exp_gap);
    end

    // Pointer after port 1: a tie goes to port 0, then port 1; port 1 noise ignored.
    req1 = 1'b1;
    en1  = 1'b1;
    txd1 = 8'hAA;
    send_frame(0, 0, 10, 10, 0, 13, 14);
    send_frame(1, 0, 5, 5, 0, 13, 14);

    // Start timeout on port 1.
    ab0 = abort_cnt;
    dn0 = done_cnt[1];
    req1 = 1'b1;
    wait_sel(1, w);
    chk("to_sel_wait", w, 13);
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i < 64) begin
        chk("to_early_abort", 32'({abort, port1_done}), 0);
        chk("to_sel_hold", 32'(port1_sel), 1);
      end else begin
        chk("to_abort", 32'(abort), 1);
        chk("to_done", 32'(port1_done), 1);
        chk("to_sel_drop", 32'(port1_sel), 0);
      end
    end
    req1 = 1'b0;
    chk("to_abort_count", abort_cnt - ab0, 1);
    chk("to_done_count", done_cnt[1] - dn0, 1);
    send_frame(0, 0, 12, 12, 0, 13, -1);

    // Request withdrawn while granted: completion without abort.
    ab0 = abort_cnt;
    req1 = 1'b1;
    wait_sel(1, w);
    chk("wd_sel_wait", w, 13);
    repeat (5) @(negedge clk);
    chk("wd_sel_hold", 32'(port1_sel), 1);
    chk("wd_no_done", 32'(port1_done), 0);
    req1 = 1'b0;
    @(negedge clk);
    chk("wd_done", 32'(port1_done), 1);
    chk("wd_sel_drop", 32'(port1_sel), 0);
    chk("wd_no_abort", abort_cnt - ab0, 0);

    // Asynchronous reset 100 cycles into a port-0 frame.
    req0 = 1'b1;
    wait_sel(0, w);
    chk("rf_sel_wait", w, 13);
    for (int k = 0; k < 100; k++) begin
      en0  = 1'b1;
      txd0 = beat(0, k);
      @(negedge clk);
    end
    chk("rf_pre_en", 32'(gmii_tx_en), 1);
    chk("rf_pre_txd", 32'(gmii_txd), 32'(beat(0, 99)));
    #2 rst = 1'b1;
    #1;
    chk("rf_en_cut", 32'(gmii_tx_en), 0);
    chk("rf_txd_cut", 32'(gmii_txd), 0);
    chk("rf_sel_cut", 32'({port0_sel, port1_sel}), 0);
    en0 = 1'b0;
    txd0 = 8'h00;
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rf_no_resume", 32'({gmii_tx_en, port0_sel, port1_sel}), 0);
    end

    // Tie right after reset: port 0 first, port 1 IFG_CYCLES+1 after port0_done.
    req1 = 1'b1;
    send_frame(0, 2, 30, 30, 0, 1, -1);
    send_frame(1, 0, 25, 25, 0, 13, 14);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
